// File: rtl/counter_stim_pkg.sv
// counter_stim_pkg: shared command/state encodings and default widths for the counter stimulus driver
package counter_stim_pkg;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ERRC_W = 8;
  typedef enum logic [1:0] {OP_LOAD, OP_UP, OP_DOWN, OP_HOLD} cmd_op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;
endpackage

// File: rtl/counter_stim_model.sv
// counter_stim_model: expected-count tracker that flags and counts mismatches against the counter's data_out
module counter_stim_model
  import counter_stim_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERRC_W = DEF_ERRC_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ld_cnt_i,
  input  logic              count_enb_i,
  input  logic              updn_cnt_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic [WIDTH-1:0]  data_out_i,
  output logic              err_o,
  output logic [ERRC_W-1:0] err_cnt_o
);
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [ERRC_W-1:0] cnt_q, cnt_d;
  logic              live_q, err_q, err_d, mis;
  // Mirror what the counter does with the drive it samples this edge; X/Z on data_out counts as a miss
  always_comb begin
    exp_d = !ld_cnt_i ? data_in_i : count_enb_i ? (updn_cnt_i ? exp_q + 1'b1 : exp_q - 1'b1) : exp_q;
    mis   = live_q && (data_out_i !== exp_q);
    err_d = err_q | mis;
    cnt_d = (mis && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // Comparison is only armed once the previous cycle was also out of reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      exp_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      live_q <= 1'b1;
    end
  end
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;
endmodule

// File: rtl/counter_stim_driver.sv
// counter_stim_driver: expands LOAD/UP/DOWN/HOLD commands into registered counter drive; COUNTER_STIM_CHECK_EN adds the expected-count checker
module counter_stim_driver
  import counter_stim_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERRC_W = DEF_ERRC_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_arg,
  output logic              ld_cnt_,
  output logic              count_enb,
  output logic              updn_cnt,
  output logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  data_out,
  output logic              busy,
  output logic              err,
  output logic [ERRC_W-1:0] err_cnt
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] rep_q, rep_d, din_q, din_d;
  logic             ld_q, ld_d, en_q, en_d, updn_q, updn_d, accept;
  cmd_op_e          op;
  assign cmd_ready = (state_q == S_IDLE) & rst_;
  assign accept    = cmd_valid & cmd_ready;
  assign op        = cmd_op_e'(cmd_op);
  // Next state and next drive; outputs are registered so the drive follows the state it belongs to
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    din_d   = din_q;
    updn_d  = updn_q;
    ld_d    = 1'b1;
    en_d    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        if (op == OP_LOAD) begin
          state_d = S_LOAD;
          ld_d    = 1'b0;
          din_d   = cmd_arg;
        end else if (cmd_arg != '0) begin
          state_d = S_RUN;
          rep_d   = cmd_arg;
          en_d    = op != OP_HOLD;
          updn_d  = op == OP_UP;
        end
      end
      S_LOAD: state_d = S_IDLE;
      S_RUN: if (rep_q == WIDTH'(1)) begin
        state_d = S_IDLE;
        rep_d   = '0;
      end else begin
        rep_d = rep_q - 1'b1;
        en_d  = en_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State and drive registers; reset abandons any command in flight
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      rep_q   <= '0;
      din_q   <= '0;
      ld_q    <= 1'b1;
      en_q    <= 1'b0;
      updn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      din_q   <= din_d;
      ld_q    <= ld_d;
      en_q    <= en_d;
      updn_q  <= updn_d;
    end
  end
  assign ld_cnt_   = ld_q;
  assign count_enb = en_q;
  assign updn_cnt  = updn_q;
  assign data_in   = din_q;
  assign busy      = state_q != S_IDLE;
`ifdef COUNTER_STIM_CHECK_EN
  counter_stim_model #(.WIDTH(WIDTH), .ERRC_W(ERRC_W)) u_model (
    .clk        (clk),
    .rst_       (rst_),
    .ld_cnt_i   (ld_q),
    .count_enb_i(en_q),
    .updn_cnt_i (updn_q),
    .data_in_i  (din_q),
    .data_out_i (data_out),
    .err_o      (err),
    .err_cnt_o  (err_cnt)
  );
`else
  logic unused_data_out;
  assign unused_data_out = ^data_out;
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_counter_stim_driver.sv
// tb_counter_stim_driver: directed bench pairing the driver with a behavioural 8-bit loadable up/down counter
module tb_counter_stim_driver;
  logic       clk = 1'b0, rst_ = 1'b0, cmd_valid = 1'b0, ovr = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_arg = 8'd0, ovr_val = 8'd0;
  logic       cmd_ready, ld_cnt_, count_enb, updn_cnt, busy, err;
  logic [7:0] data_in, data_out, cnt_q, err_cnt;
  int         total = 0, bad = 0;

  counter_stim_driver dut (
    .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ld_cnt_(ld_cnt_), .count_enb(count_enb),
    .updn_cnt(updn_cnt), .data_in(data_in), .data_out(data_out), .busy(busy),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Counter under drive: load has priority over count
  always @(posedge clk) begin
    if (!rst_) cnt_q <= 8'h00;
    else if (!ld_cnt_) cnt_q <= data_in;
    else if (count_enb) cnt_q <= updn_cnt ? cnt_q + 8'h01 : cnt_q - 8'h01;
  end
  assign data_out = ovr ? ovr_val : cnt_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] arg);
    cmd_op = op;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    chk("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input int n, input logic [7:0] start);
    logic [7:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("run_en_%0d", i), 32'(count_enb), 32'(op != 2'd3));
      if (op != 2'd3) chk($sformatf("run_dir_%0d", i), 32'(updn_cnt), 32'(op == 2'd1));
      chk($sformatf("run_busy_%0d", i), 32'(busy), 32'd1);
      @(negedge clk);
      v = (op == 2'd1) ? v + 8'h01 : (op == 2'd2) ? v - 8'h01 : v;
      chk($sformatf("run_cnt_%0d", i), 32'(data_out), 32'(v));
    end
    chk("run_en_after", 32'(count_enb), 32'd0);
    chk("run_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ld", 32'(ld_cnt_), 32'd1);
    chk("rst_en", 32'(count_enb), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din", 32'(data_in), 32'd0);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rel_cnt", 32'(data_out), 32'h00);
    chk("rel_ready", 32'(cmd_ready), 32'd1);

    issue(2'd0, 8'h5A);
    chk("ld_strobe", 32'(ld_cnt_), 32'd0);
    chk("ld_din", 32'(data_in), 32'h5A);
    chk("ld_en", 32'(count_enb), 32'd0);
    chk("ld_ready_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ld_strobe_off", 32'(ld_cnt_), 32'd1);
    chk("ld_cnt", 32'(data_out), 32'h5A);
    chk("ld_err", 32'(err), 32'd0);
    chk("ld_din_hold", 32'(data_in), 32'h5A);

    issue(2'd0, 8'hFD);
    @(negedge clk);
    chk("ld_fd", 32'(data_out), 32'hFD);
    issue(2'd1, 8'd5);
    run(2'd1, 5, 8'hFD);
    chk("up_wrap_final", 32'(data_out), 32'h02);

    issue(2'd0, 8'h02);
    @(negedge clk);
    issue(2'd2, 8'd4);
    run(2'd2, 4, 8'h02);
    chk("down_wrap_final", 32'(data_out), 32'hFE);
    issue(2'd3, 8'd3);
    run(2'd3, 3, 8'hFE);
    chk("hold_final", 32'(data_out), 32'hFE);
    chk("hold_err", 32'(err), 32'd0);

    issue(2'd1, 8'd0);
    chk("up0_en", 32'(count_enb), 32'd0);
    chk("up0_busy", 32'(busy), 32'd0);
    chk("up0_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("up0_en2", 32'(count_enb), 32'd0);
    chk("up0_cnt", 32'(data_out), 32'hFE);

    issue(2'd1, 8'd200);
    repeat (49) @(negedge clk);
    chk("up200_mid_cnt", 32'(data_out), 32'h2F);
    chk("up200_mid_en", 32'(count_enb), 32'd1);
    rst_ = 1'b0;
    @(negedge clk);
    chk("abort_en", 32'(count_enb), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ld", 32'(ld_cnt_), 32'd1);
    chk("abort_cnt", 32'(data_out), 32'h00);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_en_after", 32'(count_enb), 32'd0);
    chk("abort_cnt_after", 32'(data_out), 32'h00);
    chk("abort_ready_after", 32'(cmd_ready), 32'd1);
    chk("abort_err", 32'(err), 32'd0);

    issue(2'd0, 8'h10);
    @(negedge clk);
    chk("ld_10", 32'(data_out), 32'h10);
    ovr = 1'b1;
    repeat (2) @(negedge clk);
    ovr = 1'b0;
    repeat (2) @(negedge clk);
`ifdef COUNTER_STIM_CHECK_EN
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_cnt", 32'(err_cnt), 32'd2);
`else
    chk("mis_err_tied", 32'(err), 32'd0);
    chk("mis_cnt_tied", 32'(err_cnt), 32'd0);
`endif
    ovr = 1'b1;
    repeat (300) @(negedge clk);
    ovr = 1'b0;
    repeat (2) @(negedge clk);
`ifdef COUNTER_STIM_CHECK_EN
    chk("sat_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_err", 32'(err), 32'd1);
`else
    chk("sat_cnt_tied", 32'(err_cnt), 32'd0);
    chk("sat_err_tied", 32'(err), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
